// File: rtl/l2_pmem_responder_if.sv
// pmem bus between the L2 cache controller (master) and the memory responder (slave).
interface l2_pmem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 256
);
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_BITS-1:0]  pmem_wdata;
  logic [LINE_BITS-1:0]  pmem_rdata;
  logic                  pmem_resp;
  logic                  proto_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, proto_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, proto_err
  );
endinterface

// File: rtl/l2_pmem_responder.sv
// Line-granular main-memory stand-in for the L2 pmem port: fixed access delay, then four-beat transfer.
// Optional PMEM_RESP_JITTER_EN adds 0..7 LFSR-driven extra wait cycles per request.
module l2_pmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_BITS   = 256,
  parameter int BEAT_BITS   = 64,
  parameter int DEPTH_LINES = 512,
  parameter int LATENCY     = 10
) (
  input  logic clk,
  input  logic rst,
  l2_pmem_responder_if.slave pmem
);
  localparam int BEATS     = LINE_BITS / BEAT_BITS;
  localparam int OFF_W     = $clog2(LINE_BITS / 8);
  localparam int IDX_W     = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MEM_WORDS = DEPTH_LINES * BEATS;
  localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
`ifdef PMEM_RESP_JITTER_EN
  localparam int MAX_WAIT  = LATENCY + 7;
`else
  localparam int MAX_WAIT  = LATENCY;
`endif
  localparam int CNT_W     = $clog2(MAX_WAIT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [BEAT_W-1:0]     r_beat;
  logic [IDX_W-1:0]      r_index;
  logic                  r_is_write;
  logic [LINE_BITS-1:0]  r_wdata;
  logic [LINE_BITS-1:0]  r_rdata;
  logic                  r_err;
  logic [BEAT_BITS-1:0]  r_mem [MEM_WORDS];
`ifdef PMEM_RESP_JITTER_EN
  logic [7:0]            r_lfsr;
`endif

  logic                  w_req;
  logic                  w_drop;
  logic [CNT_W-1:0]      w_load;
  logic [MEM_AW-1:0]     w_mem_addr;
  logic                  w_unused_addr;

  assign w_req      = pmem.pmem_read | pmem.pmem_write;
  assign w_mem_addr = MEM_AW'(int'(r_index) * BEATS + int'(r_beat));
  assign w_unused_addr = ^{pmem.pmem_address[ADDR_WIDTH-1:OFF_W+IDX_W], pmem.pmem_address[OFF_W-1:0]};

`ifdef PMEM_RESP_JITTER_EN
  assign w_load = CNT_W'(LATENCY) + CNT_W'(r_lfsr[2:0]);
`else
  assign w_load = CNT_W'(LATENCY);
`endif

  // The initiator must hold the request level for the op that was captured until pmem_resp.
  assign w_drop = ((r_state == S_WAIT) || (r_state == S_BEAT)) &&
                  (r_is_write ? !pmem.pmem_write : !pmem.pmem_read);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = (w_load == '0) ? S_BEAT : S_WAIT;
      S_WAIT:  if (r_cnt == CNT_W'(1)) w_next = S_BEAT;
      S_BEAT:  if (r_beat == BEAT_W'(BEATS - 1)) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_beat     <= '0;
      r_index    <= '0;
      r_is_write <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
`ifdef PMEM_RESP_JITTER_EN
      r_lfsr     <= 8'hA5;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_index    <= pmem.pmem_address[OFF_W +: IDX_W];
            r_is_write <= pmem.pmem_write;
            r_wdata    <= pmem.pmem_wdata;
            r_cnt      <= w_load;
            r_beat     <= '0;
            // Simultaneous read and write resolves to the write.
            if (pmem.pmem_read && pmem.pmem_write) r_err <= 1'b1;
`ifdef PMEM_RESP_JITTER_EN
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
`endif
          end
        end
        S_WAIT: r_cnt <= r_cnt - CNT_W'(1);
        S_BEAT: begin
          r_beat <= r_beat + BEAT_W'(1);
          if (!r_is_write) r_rdata[int'(r_beat) * BEAT_BITS +: BEAT_BITS] <= r_mem[w_mem_addr];
        end
        default: ;
      endcase
      if (w_drop) r_err <= 1'b1;
    end
  end

  // Backing store has no reset; a reset during BEAT simply stops further beat writes.
  always_ff @(posedge clk) begin
    if ((r_state == S_BEAT) && r_is_write)
      r_mem[w_mem_addr] <= r_wdata[int'(r_beat) * BEAT_BITS +: BEAT_BITS];
  end

  assign pmem.pmem_rdata = r_rdata;
  assign pmem.pmem_resp  = (r_state == S_RESP);
  assign pmem.proto_err  = r_err;
endmodule

// File: tb/tb_l2_pmem_responder.sv
// Self-checking bench for l2_pmem_responder: line-level memory model, per-cycle compare, directed + random traffic.
module tb_l2_pmem_responder;
  localparam int LAT   = 10;
  localparam int BEATS = 4;
  localparam int DEPTH = 512;
  localparam int NEVER = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_pmem_responder_if #(.ADDR_WIDTH(32), .LINE_BITS(256)) bus ();
  l2_pmem_responder_if #(.ADDR_WIDTH(32), .LINE_BITS(256)) bus0 ();

  l2_pmem_responder #(.ADDR_WIDTH(32), .LINE_BITS(256), .BEAT_BITS(64), .DEPTH_LINES(DEPTH), .LATENCY(LAT))
    dut (.clk(clk), .rst(rst), .pmem(bus));
  l2_pmem_responder #(.ADDR_WIDTH(32), .LINE_BITS(256), .BEAT_BITS(64), .DEPTH_LINES(DEPTH), .LATENCY(0))
    dut0 (.clk(clk), .rst(rst), .pmem(bus0));

  int checkCount = 0;
  int passCount  = 0;
  int edgeCnt    = 0;

  logic [255:0] modelMem [0:DEPTH-1];
  logic [255:0] expRdata = '0;
  logic [255:0] pendData;
  logic [7:0]   modelLfsr = 8'hA5;
  bit           inFlight = 1'b0;
  bit           pendRead;
  int           pendIdx;
  int           pendResp;
  int           errEdge = NEVER;
  int           lastRespEdge = -100;
  int           lastAccept = 0;
  int           lastSeenRespEdge = -1;
  int           respCount = 0;
  int           reqCount = 0;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeCnt);
  endtask

  task automatic checkSpan(input string name, input int span, input int nominal);
`ifdef PMEM_RESP_JITTER_EN
    checkOutput(name, 256'((span >= nominal && span <= nominal + 7) ? 1 : 0), 256'(1));
`else
    checkOutput(name, 256'(span), 256'(nominal));
`endif
  endtask

  function automatic int waitCycles();
`ifdef PMEM_RESP_JITTER_EN
    return LAT + int'(modelLfsr[2:0]);
`else
    return LAT;
`endif
  endfunction

  task automatic stepLfsr();
    modelLfsr = {modelLfsr[6:0], modelLfsr[7] ^ modelLfsr[5] ^ modelLfsr[4] ^ modelLfsr[3]};
  endtask

  // Issue one request at a negedge, hold it until the model's response cycle, optionally dropping it early.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [255:0] data, input int dropAt);
    int acc;
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata   = data;
    acc = (edgeCnt + 1 > lastRespEdge + 2) ? edgeCnt + 1 : lastRespEdge + 2;
    lastAccept = acc;
    pendResp   = acc + waitCycles() + BEATS;
    stepLfsr();
    pendRead = rd && !wr;
    pendIdx  = int'((addr >> 5) % DEPTH);
    pendData = data;
    if (rd && wr && acc < errEdge) errEdge = acc;
    inFlight = 1'b1;
    reqCount++;
    lastRespEdge = pendResp;
    while (edgeCnt < pendResp) begin
      @(negedge clk);
      if (dropAt > 0 && edgeCnt == acc + dropAt - 1) begin
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        if (edgeCnt + 1 < errEdge) errEdge = edgeCnt + 1;
      end
    end
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
  endtask

  // One compare per cycle, shortly after the rising edge.
  always @(posedge clk) begin
    bit expResp;
    #1;
    if (bus.pmem_resp === 1'b1) begin
      respCount++;
      lastSeenRespEdge = edgeCnt;
    end
    expResp = inFlight && (edgeCnt == pendResp);
    checkOutput("resp", 256'(bus.pmem_resp), 256'(expResp));
    if (expResp) begin
      if (pendRead) expRdata = modelMem[pendIdx];
      else modelMem[pendIdx] = pendData;
      inFlight = 1'b0;
    end
    if (!(inFlight && pendRead)) checkOutput("rdata", bus.pmem_rdata, expRdata);
    checkOutput("proto_err", 256'(bus.proto_err), 256'((edgeCnt >= errEdge) ? 1 : 0));
  end

  localparam logic [255:0] L1 = 256'h0123456789ABCDEF_FEDCBA9876543210_1122334455667788_99AABBCCDDEEFF00;
  localparam logic [255:0] L2 = 256'hCAFEF00DDEADBEEF_0000111122223333_4444555566667777_8888999900001111;
  localparam logic [255:0] L3 = 256'h1111111111111111_2222222222222222_3333333333333333_4444444444444444;
  localparam logic [255:0] L4 = 256'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0;
  localparam logic [255:0] L5 = 256'h0000000000000001_0000000000000002_0000000000000003_0000000000000004;

  initial begin
    bit   written [8];
    int   w;
    int   t0;
    int   seen;
    int   idx;
    bit   rd;
    logic [31:0]  addr;
    logic [255:0] d;

    rst = 1'b1;
    bus.pmem_read = 1'b0;  bus.pmem_write = 1'b0;  bus.pmem_address = '0;  bus.pmem_wdata = '0;
    bus0.pmem_read = 1'b0; bus0.pmem_write = 1'b0; bus0.pmem_address = '0; bus0.pmem_wdata = '0;
    for (int i = 0; i < 8; i++) written[i] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", bus.pmem_rdata, '0);
    checkOutput("reset_resp", 256'(bus.pmem_resp), 256'(0));
    checkOutput("reset_err", 256'(bus.proto_err), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 32'h0000_0100, L1, 0);
    checkSpan("wr_latency", lastSeenRespEdge - lastAccept, 14);
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, '0, 0);
    checkSpan("rd_latency", lastSeenRespEdge - lastAccept, 14);
    checkOutput("rd_data_0100", bus.pmem_rdata, L1);

    applyStimulus(1'b0, 1'b1, 32'h0000_0120, L2, 0);
    applyStimulus(1'b1, 1'b0, 32'h0000_013F, '0, 0);
    checkOutput("rd_data_013F", bus.pmem_rdata, L2);
    applyStimulus(1'b1, 1'b0, 32'h0000_4120, '0, 0);
    checkOutput("rd_alias_4120", bus.pmem_rdata, L2);

    applyStimulus(1'b0, 1'b1, 32'h0000_0200, L3, 0);
    w = lastSeenRespEdge;
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, '0, 0);
    checkSpan("b2b_gap", lastSeenRespEdge - w, 16);
    checkOutput("b2b_data", bus.pmem_rdata, L1);
    checkOutput("b2b_err", 256'(bus.proto_err), 256'(0));

    for (int i = 0; i < 100; i++) begin
      idx  = $urandom_range(0, 7);
      addr = ($urandom & 32'hFFFF_C000) | 32'((16 + idx) << 5) | 32'($urandom_range(0, 31));
      for (int b = 0; b < 8; b++) d[b*32 +: 32] = $urandom;
      rd = written[idx] ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(rd, !rd, addr, d, 0);
      if (!rd) written[idx] = 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    applyStimulus(1'b1, 1'b1, 32'h0000_0300, L4, 0);
    checkOutput("both_err", 256'(bus.proto_err), 256'(1));
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, '0, 0);
    checkOutput("both_wrote", bus.pmem_rdata, L4);

    @(negedge clk);
    bus.pmem_read = 1'b1;
    bus.pmem_address = 32'h0000_0100;
    stepLfsr();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.pmem_read = 1'b0;
    inFlight = 1'b0;
    expRdata = '0;
    errEdge = NEVER;
    lastRespEdge = -100;
    modelLfsr = 8'hA5;
    w = respCount;
    repeat (2) @(negedge clk);
    checkOutput("abort_rdata", bus.pmem_rdata, '0);
    checkOutput("abort_err", 256'(bus.proto_err), 256'(0));
    checkOutput("abort_no_resp", 256'(respCount), 256'(w));
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0000_0400, L5, 0);
    checkSpan("post_reset_latency", lastSeenRespEdge - lastAccept, 14);

    applyStimulus(1'b1, 1'b0, 32'h0000_0400, '0, 3);
    checkOutput("drop_err", 256'(bus.proto_err), 256'(1));
    checkOutput("drop_data", bus.pmem_rdata, L5);

    @(negedge clk);
    bus0.pmem_write = 1'b1; bus0.pmem_address = 32'h0000_0040; bus0.pmem_wdata = L1;
    t0 = edgeCnt + 1;
    seen = -1;
    for (int n = 0; n < 30 && seen < 0; n++) begin
      @(negedge clk);
      if (bus0.pmem_resp === 1'b1) seen = edgeCnt;
    end
    bus0.pmem_write = 1'b0;
    checkSpan("lat0_wr", seen - t0, 4);
    @(negedge clk);
    bus0.pmem_read = 1'b1;
    t0 = edgeCnt + 1;
    seen = -1;
    for (int n = 0; n < 30 && seen < 0; n++) begin
      @(negedge clk);
      if (bus0.pmem_resp === 1'b1) seen = edgeCnt;
    end
    bus0.pmem_read = 1'b0;
    checkSpan("lat0_rd", seen - t0, 4);
    checkOutput("lat0_data", bus0.pmem_rdata, L1);
    checkOutput("lat0_err", 256'(bus0.proto_err), 256'(0));

    repeat (2) @(negedge clk);
    checkOutput("resp_count", 256'(respCount), 256'(reqCount));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
